// File: rtl/i2c_reg_arbiter.sv
// i2c_reg_arbiter
// Shares one single-port byte register bank between the I2C slave and a
// local host port. The I2C side keeps an auto-incrementing register pointer
// and always has priority. The host is granted only in cycles where no I2C
// pointer load or I2C event needs the bank.

module i2c_reg_arbiter #(
    parameter int ADDR_W = 4
) (
    input  logic              SYSTEM_CLK,
    input  logic              RESETn,
    input  logic [4:0]        i2c_state,
    input  logic [7:0]        i2c_offset,
    input  logic              i2c_wr_en,
    input  logic              i2c_rd_en,
    input  logic [7:0]        i2c_wdata,
    output logic [7:0]        i2c_rdata,
    output logic              i2c_wr_pulse,
    output logic [ADDR_W-1:0] i2c_wr_addr,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_gnt,
    output logic [7:0]        host_rdata,
    output logic              host_rvalid,
    output logic              err_ovf,
    input  logic              err_clr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [4:0] OFFSET_ACK = 5'd6;
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    logic [7:0]        bank [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic              wr_d1, wr_d2, rd_d1, rd_d2, st_d1;
    logic              wr_pend, rd_pend;

    logic wr_evt, rd_evt, wr_want, rd_want;
    logic ptr_load, offset_ovf;
    logic svc_load, svc_wr, svc_rd, svc_host;

    assign wr_evt     = wr_d1 & ~wr_d2;
    assign rd_evt     = rd_d1 & ~rd_d2;
    assign wr_want    = wr_evt | wr_pend;
    assign rd_want    = rd_evt | rd_pend;
    assign ptr_load   = st_d1 & (i2c_state != OFFSET_ACK);
    assign offset_ovf = (i2c_offset >> ADDR_W) != 8'd0;

    // Pick the single bank user for this cycle: pointer load, I2C write,
    // I2C read, host, in that order. Reset also withdraws any host grant.
    always_comb begin
        svc_load = 1'b0;
        svc_wr   = 1'b0;
        svc_rd   = 1'b0;
        svc_host = 1'b0;
        if (ptr_load) begin
            svc_load = 1'b1;
        end else if (wr_want) begin
            svc_wr = 1'b1;
        end else if (rd_want) begin
            svc_rd = 1'b1;
        end else if (host_req && RESETn) begin
            svc_host = 1'b1;
        end
    end

    assign host_gnt = svc_host;

    // Delay the slave's level enables and the offset-ack state so rising
    // edges can be detected and rx_data has settled by service time.
    always_ff @(posedge SYSTEM_CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_d1 <= 1'b0;
            wr_d2 <= 1'b0;
            rd_d1 <= 1'b0;
            rd_d2 <= 1'b0;
            st_d1 <= 1'b0;
        end else begin
            wr_d1 <= i2c_wr_en;
            wr_d2 <= wr_d1;
            rd_d1 <= i2c_rd_en;
            rd_d2 <= rd_d1;
            st_d1 <= (i2c_state == OFFSET_ACK);
        end
    end

    // Pointer, pending I2C events and the sticky overflow flag. An event that
    // is not serviced in its own cycle stays pending until it wins.
    always_ff @(posedge SYSTEM_CLK or negedge RESETn) begin
        if (!RESETn) begin
            ptr     <= '0;
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            wr_pend <= (wr_pend | wr_evt) & ~svc_wr;
            rd_pend <= (rd_pend | rd_evt) & ~svc_rd;
            if (svc_load) begin
                ptr <= i2c_offset[ADDR_W-1:0];
            end else if (svc_wr || svc_rd) begin
                ptr <= ptr + PTR_ONE;
            end
            if (svc_load && offset_ovf) begin
                err_ovf <= 1'b1;
            end else if (err_clr) begin
                err_ovf <= 1'b0;
            end
        end
    end

    // Bank access and the registered read/strobe outputs of both ports.
    always_ff @(posedge SYSTEM_CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= 8'h00;
            end
            i2c_rdata    <= 8'h00;
            i2c_wr_addr  <= '0;
            i2c_wr_pulse <= 1'b0;
            host_rdata   <= 8'h00;
            host_rvalid  <= 1'b0;
        end else begin
            i2c_wr_pulse <= svc_wr;
            host_rvalid  <= svc_host & ~host_we;
            if (svc_wr) begin
                bank[ptr]   <= i2c_wdata;
                i2c_wr_addr <= ptr;
            end else if (svc_host && host_we) begin
                bank[host_addr] <= host_wdata;
            end
            if (svc_rd) begin
                i2c_rdata <= bank[ptr];
            end
            if (svc_host && !host_we) begin
                host_rdata <= bank[host_addr];
            end
        end
    end

endmodule

// File: doc/i2c_reg_arbiter.md
# i2c_reg_arbiter

- Shares a single-port byte register bank between the I2C slave and a local host port.
- Turns the slave's level write/read enables into single-cycle bank accesses, and keeps the I2C auto-incrementing register pointer.
- Supplies read bytes to the slave's tx_data before the slave loads them.
- Sits between i2c_slave and local control logic; the I2C side has fixed priority.

## Interface
- ADDR_W, 4, bank address width; DEPTH = 2^ADDR_W bytes.
- SYSTEM_CLK  in  1  single clock.
- RESETn  in  1  asynchronous, active-low reset.
- i2c_state  in  5  slave ostate; value 6 = OFFSET_ACK.
- i2c_offset  in  8  slave rx_offset.
- i2c_wr_en  in  1  slave owrite_en (level, many cycles).
- i2c_rd_en  in  1  slave oread_en (level, many cycles).
- i2c_wdata  in  8  slave rx_data.
- i2c_rdata  out  8  to slave tx_data, registered.
- i2c_wr_pulse  out  1  one-cycle strobe per completed I2C write.
- i2c_wr_addr  out  ADDR_W  bank address of the last I2C write.
- host_req  in  1  host access request; held until host_gnt.
- host_we  in  1  1 = write, 0 = read; stable while host_req=1.
- host_addr  in  ADDR_W  host bank address; stable while host_req=1.
- host_wdata  in  8  host write data; stable while host_req=1.
- host_gnt  out  1  one-cycle grant; access executes on this cycle.
- host_rdata  out  8  read data, registered.
- host_rvalid  out  1  one-cycle pulse, the cycle after a read grant.
- err_ovf  out  1  sticky: an I2C offset was >= DEPTH.
- err_clr  in  1  clears err_ovf.

## Operation
- Bank: DEPTH x 8 flops; one access (read or write) per cycle.
- Edge detect: the I2C enables pass through two registers (d1, d2).
  - wr_evt = wr_d1 & ~wr_d2.
  - rd_evt = rd_d1 & ~rd_d2.
  - The d1 delay guarantees i2c_wdata is valid; the slave updates rx_data on the first ACK_WR cycle.
- Pointer ptr[ADDR_W-1:0]:
  - st_d1 registers (i2c_state==6).
  - When st_d1=1 and the current i2c_state != 6, load ptr <= i2c_offset[ADDR_W-1:0].
  - On that same load, if i2c_offset >= DEPTH, set err_ovf.
- Each I2C write or read post-increments ptr modulo DEPTH; DEPTH-1 wraps to 0.
- Per-cycle arbitration priority: pointer load > wr_evt > rd_evt > host_req.
  - Pointer load and wr_evt/rd_evt cannot coincide under the slave protocol. If forced to, apply the load, then service the event against the new ptr on the next cycle, keeping the event pending.
- wr_evt and rd_evt each set a pending flag, cleared when serviced. A pending I2C event always wins over host_req.
- I2C write service: bank[ptr] <= i2c_wdata; i2c_wr_addr <= ptr; i2c_wr_pulse=1 on the following cycle; ptr++.
- I2C read service: i2c_rdata <= bank[ptr]; ptr++. A read with no preceding offset phase uses the current ptr.
- Host service (no I2C pending): host_gnt=1.
  - Write: bank[host_addr] <= host_wdata.
  - Read: host_rdata <= bank[host_addr]; host_rvalid=1 on the next cycle.
- Host read and I2C write to the same address in consecutive cycles: the later access sees the earlier write.
- err_clr and err_ovf set in the same cycle: set wins.
- Reset values: bank, ptr, i2c_rdata, i2c_wr_addr, host_rdata = 0; i2c_wr_pulse, host_gnt, host_rvalid, err_ovf, pending flags, d1/d2 = 0.
- Reset mid-operation drops every pending event and grant at once.

## Timing
- i2c_rd_en rises before edge t:
  - rd_d1=1 after t; rd_evt during t..t+1.
  - Serviced at edge t+1 if nothing higher is pending.
  - i2c_rdata valid after t+1; worst case after t+2 if a pointer load collides.
- I2C write: bank updated at edge t+1; i2c_wr_pulse high for the cycle after t+1.
- Host latency:
  - host_gnt asserts combinationally in the first cycle with host_req=1 and no I2C pending.
  - Maximum wait is 2 cycles per I2C event.
  - Next grant earliest the cycle after host_req is re-asserted; back-to-back grants are allowed if host_req stays high with new data.
- Constraint: SYSTEM_CLK >= 20 x SCL, so i2c_rdata settles before the slave's SCL-fall load.

## Test plan
- Reset -> all outputs 0; host read of address 5 -> host_rvalid with host_rdata=0x00.
- I2C write, offset 0x03, bytes 0xA1, 0xB2 -> bank[3]=0xA1, bank[4]=0xB2; two i2c_wr_pulse with i2c_wr_addr 3 then 4; final ptr=5.
- I2C read, offset 0x0F (ADDR_W=4), three bytes, bank[15]=0x11, bank[0]=0x22, bank[1]=0x33 -> i2c_rdata 0x11, 0x22, 0x33 (wrap), each within 3 cycles of the i2c_rd_en rise.
- host_req held high across the I2C write edge event -> host_gnt delayed exactly 1 cycle; host write 0x5A to address 2 lands afterwards; I2C data intact.
- Offset 0x20 loaded -> err_ovf=1, ptr=0; err_clr=1 in the same cycle as another overflow -> err_ovf stays 1; err_clr alone -> 0.
- RESETn low while rd_evt is pending -> no i2c_rdata update after release; ptr=0; bank cleared.
